// File: rtl/mem_stage.sv
// Memory-access pipeline stage: owns the EX/MEM register, aligns/extends load
// data from the data SRAM and drives the MEM-to-WB and MEM-to-ID bypass buses.
// A small IDLE/WAIT/HOLD FSM covers variable read latency and WB back-pressure.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   stall[5:0]          controller stall vector; [3] freezes EX/MEM, [4] freezes MEM/WB
//   ex_to_mem_bus       {pc, data_ram_en, data_ram_wen, ld_type, sel_rf_res, rf_we, rf_waddr, ex_result}
//   data_sram_rdata     read data, meaningful only with data_sram_rvalid
//   data_sram_rvalid    single-cycle read-response strobe
//   mem_to_wb_bus       {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_id_bus       bypass {rf_we, rf_waddr, rf_wdata}
//   stallreq_mem        asks the controller to stall stages 0..4 while load data is outstanding
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_ID_WD = 38,
    parameter int StallBus     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_rvalid,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    stallreq_mem
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

    logic [EX_TO_MEM_WD-1:0] ex_mem_q, ex_mem_d;
    state_e                  state_q, state_d;
    logic [31:0]             hold_buf_q, hold_buf_d;

    // Only the EX/MEM and MEM/WB stall bits matter here.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[StallBus-1:5], stall[2:0]};

    // Field decode of the registered EX/MEM bus.
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic [2:0]  ld_type;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign {pc, data_ram_en, data_ram_wen, ld_type, sel_rf_res,
            rf_we, rf_waddr, ex_result} = ex_mem_q;

    logic is_load;
    assign is_load = data_ram_en & (data_ram_wen == 4'b0000) & sel_rf_res;

    // Byte lane from addr[1:0], halfword from addr[1]; unknown ld_type codes read as LW.
    function automatic logic [31:0] align_load(input logic [2:0]  t,
                                               input logic [1:0]  a,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (t)
            3'b001:  align_load = {{24{b[7]}}, b};
            3'b010:  align_load = {24'd0, b};
            3'b011:  align_load = {{16{h[15]}}, h};
            3'b100:  align_load = {16'd0, h};
            default: align_load = d;
        endcase
    endfunction

    // Once parked in HOLD the SRAM may have moved on, so read from the buffer.
    logic [31:0] load_src;
    logic [31:0] rf_wdata;
    assign load_src = (state_q == S_HOLD) ? hold_buf_q : data_sram_rdata;
    assign rf_wdata = is_load ? align_load(ld_type, ex_result[1:0], load_src) : ex_result;

    assign stallreq_mem = is_load & ~data_sram_rvalid & (state_q != S_HOLD);

    // Never forward or write back a load whose data has not arrived yet.
    logic rf_we_eff;
    assign rf_we_eff = rf_we & ~stallreq_mem;

    assign mem_to_wb_bus = {pc, rf_we_eff, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we_eff, rf_waddr, rf_wdata};

    // EX/MEM register: bubble when EX/MEM stalls but MEM/WB drains.
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (stall[3] && !stall[4]) begin
            ex_mem_d = '0;
        end else if (!stall[3]) begin
            ex_mem_d = ex_to_mem_bus;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_buf_d = hold_buf_q;
        case (state_q)
            S_IDLE: begin
                if (is_load && !data_sram_rvalid) begin
                    state_d = S_WAIT;
                end else if (is_load && data_sram_rvalid && stall[4]) begin
                    state_d    = S_HOLD;
                    hold_buf_d = data_sram_rdata;
                end
            end
            S_WAIT: begin
                if (is_load && data_sram_rvalid && stall[4]) begin
                    state_d    = S_HOLD;
                    hold_buf_d = data_sram_rdata;
                end else if (data_sram_rvalid && !stall[4]) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!stall[4]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q   <= '0;
            state_q    <= S_IDLE;
            hold_buf_q <= '0;
        end else begin
            ex_mem_q   <= ex_mem_d;
            state_q    <= state_d;
            hold_buf_q <= hold_buf_d;
        end
    end

    // A load parked in WAIT/HOLD relies on the controller freezing EX/MEM.
    a_load_frozen: assert property (@(posedge clk) disable iff (rst)
        ((state_q != S_IDLE) && (stallreq_mem || stall[4])) |-> stall[3]);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_tb;
    logic [5:0]  stall;
    logic [78:0] ex_bus;
    logic [31:0] rdata;
    logic        rvalid;
    logic [69:0] wb;
    logic [37:0] idb;
    logic        stallreq;

    int checks = 0;
    int passes = 0;
    logic [69:0] exp_q[$];

    always #5 clk = ~clk;

    // Simple controller: a memory stall request freezes stages 0..4.
    assign stall = stallreq ? 6'b011111 : stall_tb;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_to_mem_bus    (ex_bus),
        .data_sram_rdata  (rdata),
        .data_sram_rvalid (rvalid),
        .mem_to_wb_bus    (wb),
        .mem_to_id_bus    (idb),
        .stallreq_mem     (stallreq)
    );

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {69'd0, act}, {69'd0, exp});
    endtask

    // Reference load result computed arithmetically from the load rules.
    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a,
                                             input logic [31:0] d);
        int unsigned b, h;
        int s;
        b = (d >> (8 * a)) % 256;
        h = (d >> (16 * a[1])) % 65536;
        case (t)
            3'd1: begin s = (b >= 128) ? int'(b) - 256 : int'(b); return 32'(s); end
            3'd2: return 32'(b);
            3'd3: begin s = (h >= 32768) ? int'(h) - 65536 : int'(h); return 32'(s); end
            3'd4: return 32'(h);
            default: return d;
        endcase
    endfunction

    // Scoreboard monitor: WB captures whenever stall[4] is released; pc 0 marks a bubble.
    always @(negedge clk) begin
        logic [69:0] e;
        if (!rst && !stall[4] && wb[69:38] != 32'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL wb_unexpected: got %h expected nothing", wb);
            end else begin
                e = exp_q.pop_front();
                check("wb_bus", wb, e);
                check("id_bus", {32'd0, idb}, {32'd0, e[37:0]});
            end
        end
    end

    // kind: 0 ALU, 1 store, 2 load, 3 memory-enabled non-load (sel_rf_res=0)
    task automatic issue(input logic [31:0] pc, input int kind, input logic [2:0] lt,
                         input logic we, input logic [4:0] wa, input logic [31:0] exr,
                         input logic [31:0] rd, input int lat, input int hold,
                         input int nst, input logic bub);
        logic [78:0] bus;
        logic [95:0] garbage;
        logic        ld, en, sel;
        logic [3:0]  wen;
        logic [31:0] wd;
        logic [69:0] e;
        ld  = (kind == 2);
        en  = (kind != 0);
        wen = (kind == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        sel = ld ? 1'b1 : ((kind == 3) ? 1'b0 : 1'($urandom));
        bus = {pc, en, wen, lt, sel, we, wa, exr};
        wd  = ld ? ref_load(lt, exr[1:0], rd) : exr;
        e   = {pc, we, wa, wd};

        ex_bus = bus; stall_tb = '0; rvalid = 1'b0; rdata = $urandom;
        @(posedge clk); #1;
        ex_bus = '0;
        if (!ld) begin
            for (int i = 0; i < nst; i++) begin
                stall_tb = 6'b011111; rvalid = 1'($urandom); rdata = $urandom;
                @(negedge clk);
                check("held_bus", wb, e);
                check1("nonload_no_stallreq", stallreq, 1'b0);
                @(posedge clk); #1;
            end
            rvalid = 1'($urandom); rdata = $urandom;
        end else begin
            for (int i = 0; i < lat; i++) begin
                stall_tb = '0; rvalid = 1'b0; rdata = $urandom;
                @(negedge clk);
                check1("stallreq_waiting", stallreq, 1'b1);
                check1("wb_we_masked", wb[37], 1'b0);
                check1("id_we_masked", idb[37], 1'b0);
                @(posedge clk); #1;
            end
            rvalid = 1'b1; rdata = rd;
            for (int i = 0; i < hold; i++) begin
                stall_tb = 6'b011111;
                @(negedge clk);
                check1("stallreq_hold", stallreq, 1'b0);
                check("hold_bus", wb, e);
                @(posedge clk); #1;
                rvalid = 1'($urandom); rdata = $urandom;
            end
        end

        // Commit cycle: either plain advance or bubble insertion with junk on the input.
        exp_q.push_back(e);
        if (bub) begin
            garbage  = {$urandom, $urandom, $urandom};
            stall_tb = 6'b001111;
            ex_bus   = garbage[78:0];
            ex_bus[78:47] = 32'hDEAD_0000 | 32'(garbage[15:0]);
        end else begin
            stall_tb = '0;
            ex_bus   = '0;
        end
        @(negedge clk);
        @(posedge clk); #1;
        ex_bus = '0; stall_tb = '0; rvalid = 1'b0;
        @(negedge clk);
        check("empty_after_commit", wb, 70'd0);
    endtask

    task automatic reset_in_wait();
        ex_bus = {32'h0000_0BAD, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 5'd7, 32'h0000_0040};
        stall_tb = '0; rvalid = 1'b0;
        @(posedge clk); #1;
        ex_bus = '0;
        @(posedge clk); #3;
        check1("pre_reset_stallreq", stallreq, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_wb_zero", wb, 70'd0);
        check("rst_id_zero", {32'd0, idb}, 70'd0);
        check1("rst_stallreq", stallreq, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        rvalid = 1'b1; rdata = $urandom;
        @(negedge clk);
        check("late_rvalid_no_write", wb, 70'd0);
        check1("late_rvalid_stallreq", stallreq, 1'b0);
        @(posedge clk); #1;
        rvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall_tb = '0; ex_bus = '0; rdata = '0; rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_wb", wb, 70'd0);
        check("reset_id", {32'd0, idb}, 70'd0);
        check1("reset_stallreq", stallreq, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h100, 0, 3'd0, 1'b1, 5'd5,  32'h1234_5678, 32'd0,         0, 0, 0, 1'b0);
        issue(32'h104, 2, 3'd1, 1'b1, 5'd3,  32'h0000_0003, 32'h80FF_0000, 0, 0, 0, 1'b0);
        issue(32'h108, 2, 3'd2, 1'b1, 5'd3,  32'h0000_0003, 32'h80FF_0000, 0, 0, 0, 1'b0);
        issue(32'h10C, 2, 3'd4, 1'b1, 5'd9,  32'h0000_0002, 32'hBEEF_1234, 3, 0, 0, 1'b0);
        issue(32'h110, 2, 3'd0, 1'b1, 5'd10, 32'h0000_0000, 32'hCAFE_F00D, 0, 2, 0, 1'b0);
        issue(32'h114, 0, 3'd0, 1'b1, 5'd11, 32'hA5A5_5A5A, 32'd0,         0, 0, 2, 1'b1);
        reset_in_wait();
        issue(32'h118, 2, 3'd3, 1'b1, 5'd12, 32'h0000_0001, 32'h0012_8034, 1, 1, 0, 1'b1);

        for (int i = 0; i < 250; i++) begin
            issue(32'h1000 + 32'(i) * 4, $urandom_range(0, 3), 3'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom), $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                  1'($urandom));
        end

        check("scoreboard_drained", 70'(exp_q.size()), 70'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
